seg7_capture: RTL
=================

# seg7_capture

Observer for a seven-segment display bus. It samples the 7-bit segment pattern the chip drives on `uo_out[6:0]` and waits until the pattern has been stable for a programmable number of cycles. It then decodes the pattern back into a hex digit and queues the result in a small ready/valid FIFO. It sits on the harness side of the top-level pins and turns the display output into a checkable digit stream.

## Interface
- `STABLE_CYCLES`, default 4: consecutive equal samples required before a pattern is accepted; legal range 1–15.
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  capture enable; when low, no new patterns are accepted.
- `seg_in`  in  7  segment pattern; bit0 = a, bit1 = b, and so on up to bit6 = g; active-high.
- `out_valid`  out  1  FIFO head holds a decoded entry.
- `out_ready`  in  1  consumer accepts the head when asserted together with `out_valid`.
- `out_digit`  out  4  decoded hex value at the FIFO head; 0 when empty.
- `out_err`  out  1  head entry came from a pattern that is not a legal glyph; 0 when empty.
- `overflow`  out  1  sticky flag: an accepted pattern was dropped because the FIFO was full.

## Operation
- Glyph table (hex value, then pattern):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
- State machine, two states:
  - SETTLE: counting stability.
  - LOCKED: current pattern already accepted; waiting for it to change.
- Registers: `seg_q` (last sample), `cnt` (stability count), `last_acc` (last accepted pattern).
- On every edge, `seg_q` takes `seg_in`.
- If `seg_in != seg_q` or `ena` is low: `cnt` clears to 0 and the state goes to SETTLE.
- Otherwise, in SETTLE: `cnt` increments. When `cnt` reaches `STABLE_CYCLES`, the pattern is accepted and the state goes to LOCKED.
- In LOCKED, `cnt` holds and nothing further is pushed.
- On acceptance, if `seg_q == last_acc`: no push (a momentary glitch back to the same glyph is not re-reported).
- On acceptance, if the pattern is blank (0x00): `last_acc` updates, no push.
- On acceptance, if the pattern matches the glyph table: push {err=0, digit}.
- On acceptance, any other pattern: push {err=1, digit=0}.
- Every acceptance updates `last_acc`.
- FIFO write rules:
  - If full and no pop happens in the same cycle: the entry is dropped and `overflow` is set. `overflow` clears only on reset.
  - Push and pop in the same cycle while full: both succeed; no overflow.
  - Push and pop in the same cycle while empty: the push lands and `out_valid` rises next cycle (no bypass path).
- A pop happens when `out_valid && out_ready`. `out_ready` while empty is ignored.
- Reset mid-operation: FIFO is emptied, the state machine returns to SETTLE, `cnt` = 0, `last_acc` = 0x00.

## Timing
- Reset values: `out_valid`=0, `out_digit`=0, `out_err`=0, `overflow`=0; `seg_q` = 0x00.
- Latency: pattern P first present before edge 0 and held → push occurs at edge `STABLE_CYCLES`. `out_valid` is high after that edge, i.e. `STABLE_CYCLES`+1 edges total.
- A pattern change resets the count on the edge where the change is first sampled.
- All outputs are registered or decoded directly from FIFO registers. There are no combinational paths from `seg_in` or `out_ready` to any output.
- Pop takes effect at the edge; the next head appears in the same cycle as the decremented count.

## Structure
- Package `seg7_pkg` holds:
  - the 16 glyph constants;
  - a decode function mapping a 7-bit pattern to {err, digit[3:0]};
  - the state enum {SETTLE, LOCKED}.
- Sub-module `seg7_fifo`: generic DEPTH×5-bit synchronous FIFO with push/pop, full/empty, and the same `clk`/`rst_n` conventions. The top level holds the stability counter, state machine and overflow logic.

## Test plan
- Reset, hold `seg_in`=0x00, `ena`=1, for 20 cycles → `out_valid` stays 0 and `overflow`=0.
- Drive 0x5B for 5 cycles (`STABLE_CYCLES`=4) → `out_valid` rises after edge 4 with `out_digit`=2, `out_err`=0. One pop → `out_valid`=0.
- Drive 0x06 for 3 cycles, then 0x00, then 0x06 for 2 cycles → nothing pushed; count restarts at every change.
- Drive 0x06 stable, then a one-cycle 0x00 glitch, then 0x06 stable for 10 cycles → exactly one entry, digit 1.
- Drive 0x7F then 0x12 (each stable ≥5 cycles) → entries {0,8} then {1,0}.
- Hold `out_ready`=0 and accept 5 distinct glyphs → 4 entries retained, `overflow`=1. Assert `rst_n`=0 mid-stream → all outputs back to 0 immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture path: glyph patterns,
// pattern decoder and capture state encoding.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;
    localparam logic [6:0] BLANK   = 7'h00;

    typedef enum logic [0:0] {SETTLE, LOCKED} state_e;

    // err sits in the MSB so the packed entry maps straight onto the 5-bit FIFO word
    typedef struct packed {
        logic       err;
        logic [3:0] digit;
    } entry_t;

    function automatic entry_t decode(input logic [6:0] pat);
        entry_t e;
        e.err = 1'b0;
        case (pat)
            GLYPH_0: e.digit = 4'h0;
            GLYPH_1: e.digit = 4'h1;
            GLYPH_2: e.digit = 4'h2;
            GLYPH_3: e.digit = 4'h3;
            GLYPH_4: e.digit = 4'h4;
            GLYPH_5: e.digit = 4'h5;
            GLYPH_6: e.digit = 4'h6;
            GLYPH_7: e.digit = 4'h7;
            GLYPH_8: e.digit = 4'h8;
            GLYPH_9: e.digit = 4'h9;
            GLYPH_A: e.digit = 4'hA;
            GLYPH_B: e.digit = 4'hB;
            GLYPH_C: e.digit = 4'hC;
            GLYPH_D: e.digit = 4'hD;
            GLYPH_E: e.digit = 4'hE;
            GLYPH_F: e.digit = 4'hF;
            default: begin
                e.err   = 1'b1;
                e.digit = 4'h0;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/seg7_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module seg7_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so a push into a full FIFO may proceed
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment bus observer: waits for a stable pattern, decodes it and
// queues {err, digit} entries for a ready/valid consumer.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [6:0] seg_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_err,
    output logic       overflow
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

    state_e     state, state_d;
    logic [6:0] seg_q, last_acc, last_acc_d;
    logic [3:0] cnt, cnt_d;
    logic       accept, push, pop, full, empty, overflow_d;
    entry_t     push_entry, head;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        if (seg_in != seg_q || !ena) begin
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state == SETTLE) begin
            cnt_d = cnt + 4'd1;
            if (cnt_d == STABLE_CNT) begin
                accept  = 1'b1;
                state_d = LOCKED;
            end
        end
    end

    // Re-accepting the previous glyph after a glitch, or a blank display, produces no entry
    always_comb begin
        last_acc_d = accept ? seg_q : last_acc;
        push       = accept && (seg_q != last_acc) && (seg_q != BLANK);
        push_entry = decode(seg_q);
        pop        = out_valid && out_ready;
        overflow_d = overflow || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SETTLE;
            seg_q    <= BLANK;
            cnt      <= '0;
            last_acc <= BLANK;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            seg_q    <= seg_in;
            cnt      <= cnt_d;
            last_acc <= last_acc_d;
            overflow <= overflow_d;
        end
    end

    seg7_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        out_valid = !empty;
        out_digit = empty ? 4'h0 : head.digit;
        out_err   = empty ? 1'b0 : head.err;
    end

endmodule
